// File: rtl/color_sampler.sv
// color_sampler: averages a square window of an RGB565 pixel stream once per
// frame and presents the result as a held RGB888 colour for the LED driver.

// Per-channel accumulate / average / hold lane.
module color_chan #(
  parameter int ACC_W = 16,
  parameter int SHIFT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic       stage,
  input  logic       load,
  input  logic [7:0] pix,
  output logic [7:0] data
);
  logic [ACC_W-1:0] acc;
  logic [7:0]       avg_q;

  // Window sum; a restart may coincide with the first pixel of the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= add ? ACC_W'(pix) : '0;
    else if (add) acc <= acc + ACC_W'(pix);
  end

  // Floor average is staged, then published; the published value is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_q <= '0;
      data  <= '0;
    end else begin
      if (stage) avg_q <= acc[ACC_W-1:SHIFT];
      if (load)  data  <= avg_q;
    end
  end
endmodule

module color_sampler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIN_X0   = 312,
  parameter int WIN_Y0   = 232,
  parameter int WIN_LOG2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic [7:0]  data_r,
  output logic [7:0]  data_g,
  output logic [7:0]  data_b,
  output logic        data_valid,
  output logic        frame_err
);
  localparam int XW     = $clog2(H_ACTIVE);
  localparam int YW     = $clog2(V_ACTIVE);
  localparam int SHIFT  = 2 * WIN_LOG2;
  localparam int ACC_W  = 8 + SHIFT;
  localparam int WIN    = 1 << WIN_LOG2;
  localparam int STAGES = 2;

  localparam logic [XW-1:0] X_LO   = XW'(WIN_X0);
  localparam logic [XW-1:0] X_LAST = XW'(WIN_X0 + WIN - 1);
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LO   = YW'(WIN_Y0);
  localparam logic [YW-1:0] Y_LAST = YW'(WIN_Y0 + WIN - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state, next_state;
  logic [XW-1:0]       x, cnt_x;
  logic [YW-1:0]       y, cnt_y;
  logic                take, in_win, add, last;
  logic [STAGES:1]     vld_pipe;
  logic [2:0][7:0]     pix8;
  logic [2:0][7:0]     chan_data;

  // RGB565 -> RGB888 by replicating the top bits into the low bits.
  assign pix8[2] = {pix_data[15:11], pix_data[15:13]};
  assign pix8[1] = {pix_data[10:5],  pix_data[10:9]};
  assign pix8[0] = {pix_data[4:0],   pix_data[4:2]};

  // Position of the pixel counted this cycle; a restart counts it as (0,0).
  always_comb begin
    cnt_x  = frame_start ? '0 : x;
    cnt_y  = frame_start ? '0 : y;
    take   = pix_valid && (frame_start || state == ACCUM) && (cnt_y < Y_MAX);
    in_win = (cnt_x >= X_LO) && (cnt_x <= X_LAST) &&
             (cnt_y >= Y_LO) && (cnt_y <= Y_LAST);
    add    = take && in_win;
    last   = take && (cnt_x == X_LAST) && (cnt_y == Y_LAST);
  end

  // Raster counters; y parks at V_ACTIVE once the frame's active area is done.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      x <= '0;
      y <= '0;
    end else if (take) begin
      if (cnt_x == X_END) begin
        x <= '0;
        y <= cnt_y + YW'(1);
      end else begin
        x <= cnt_x + XW'(1);
        y <= cnt_y;
      end
    end else if (frame_start) begin
      x <= '0;
      y <= '0;
    end
  end

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  // Next state: any frame_start (re)enters ACCUM; DONE lasts one cycle.
  always_comb begin
    next_state = state;
    if (frame_start || state == ACCUM) next_state = last ? DONE : ACCUM;
    else if (state == DONE)            next_state = IDLE;
  end

  // Result publish pipeline and abort strobe.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_pipe  <= '0;
      frame_err <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], state == DONE};
      frame_err <= (state == ACCUM) && frame_start;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_chan
    color_chan #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_chan (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .clr  (frame_start),
      .add  (add),
      .stage(state == DONE),
      .load (vld_pipe[1]),
      .pix  (pix8[c]),
      .data (chan_data[c])
    );
  end

  assign data_r     = chan_data[2];
  assign data_g     = chan_data[1];
  assign data_b     = chan_data[0];
  assign data_valid = vld_pipe[STAGES];
endmodule
